// File: rtl/fsm_out_deserializer_pkg.sv
// fsm_io_pkg
// Shared definitions for the Mealy detector output path: the 2-bit state
// encoding of the deserializer FSM and the default packed-word width. The
// upstream FSM bench imports the same package.
package fsm_io_pkg;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_STALL = 2'b10;

    localparam int DEFAULT_WIDTH = 8;

    // Width needed to hold a ones count ranging from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fsm_out_deserializer_if.sv
// fsm_out_deserializer_if
// Bundles the serial-bit input side and the valid/ready word output side of
// the deserializer.
//   y_in, bit_valid, clear : serial bit stream, bit qualifier, flush
//   word_out, ones_cnt     : packed word (first bit in MSB) and its popcount
//   word_valid, word_ready : output handshake
//   overflow               : sticky dropped-bit flag
// slave  : the deserializer itself
// master : the producer/consumer environment around it
interface fsm_out_deserializer_if
    import fsm_io_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             y_in;
    logic             bit_valid;
    logic             clear;
    logic [WIDTH-1:0] word_out;
    logic [CNT_W-1:0] ones_cnt;
    logic             word_valid;
    logic             word_ready;
    logic             overflow;

    modport slave (
        input  y_in, bit_valid, clear, word_ready,
        output word_out, ones_cnt, word_valid, overflow
    );

    modport master (
        output y_in, bit_valid, clear, word_ready,
        input  word_out, ones_cnt, word_valid, overflow
    );
endinterface

// File: rtl/fsm_out_deserializer_popcount.sv
// popcount
// Purely combinational population count of a WIDTH-bit vector.
//   data_in   : vector to count
//   count_out : number of 1 bits in data_in (0..WIDTH)
module popcount #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_in,
    output logic [CNT_W-1:0] count_out
);

    // Sum the bits one at a time; synthesis builds the adder tree.
    always_comb begin
        count_out = {CNT_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            count_out = count_out + CNT_W'(data_in[i]);
        end
    end

endmodule

// File: rtl/fsm_out_deserializer.sv
// fsm_out_deserializer
// Packs qualified bits of the detector output stream MSB-first into WIDTH-bit
// words and offers them with their popcount on a valid/ready interface. The
// output register plus a full shift register give two words of buffering;
// a bit arriving when both are occupied is dropped and sets sticky overflow.
//   CLK     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : fsm_out_deserializer_if slave (bit input, word output, overflow)
module fsm_out_deserializer
    import fsm_io_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   CLK,
    input  logic                   Reset_n,
    fsm_out_deserializer_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [1:0]       state_r, state_s;
    logic [WIDTH-1:0] sh_r, sh_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] word_r;
    logic [CNT_W-1:0] ones_r;
    logic             valid_r;
    logic             ovf_r, ovf_s;

    logic             drain_s;
    logic             free_s;
    logic             load_s;
    logic [WIDTH-1:0] shift_word_s;
    logic [WIDTH-1:0] load_word_s;
    logic [CNT_W-1:0] load_ones_s;

    assign drain_s      = valid_r && bus.word_ready;
    assign free_s       = !valid_r || drain_s;
    assign shift_word_s = {sh_r[WIDTH-2:0], bus.y_in};

    popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_popcount (
        .data_in   (load_word_s),
        .count_out (load_ones_s)
    );

    // Next-state, shift/count and overflow decisions; clear overrides bit intake.
    always_comb begin
        state_s     = state_r;
        sh_s        = sh_r;
        cnt_s       = cnt_r;
        ovf_s       = ovf_r;
        load_s      = 1'b0;
        load_word_s = shift_word_s;
        if (bus.clear) begin
            state_s = S_IDLE;
            sh_s    = {WIDTH{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
            ovf_s   = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.bit_valid) begin
                        sh_s    = shift_word_s;
                        cnt_s   = CNT_W'(1);
                        state_s = S_SHIFT;
                    end else begin
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end
                S_SHIFT: begin
                    if (bus.bit_valid) begin
                        sh_s = shift_word_s;
                        if (cnt_r == CNT_W'(WIDTH - 1)) begin
                            // Completed word bypasses sh when the output register can take it.
                            if (free_s) begin
                                load_s  = 1'b1;
                                cnt_s   = {CNT_W{1'b0}};
                                state_s = S_IDLE;
                            end else begin
                                cnt_s   = CNT_W'(WIDTH);
                                state_s = S_STALL;
                            end
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                S_STALL: begin
                    load_word_s = sh_r;
                    if (drain_s) begin
                        load_s = 1'b1;
                        if (bus.bit_valid) begin
                            // sh_r is consumed this edge, so the new bit may shift in now.
                            sh_s    = shift_word_s;
                            cnt_s   = CNT_W'(1);
                            state_s = S_SHIFT;
                        end else begin
                            cnt_s   = {CNT_W{1'b0}};
                            state_s = S_IDLE;
                        end
                    end else if (bus.bit_valid) begin
                        ovf_s = 1'b1;
                    end else begin
                        ovf_s = ovf_r;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, shift register, bit count and overflow flops.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= S_IDLE;
            sh_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            sh_r    <= sh_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
        end
    end

    // Output register: load a new word, or drop valid on a drain with nothing new.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            word_r  <= {WIDTH{1'b0}};
            ones_r  <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
        end else if (load_s) begin
            word_r  <= load_word_s;
            ones_r  <= load_ones_s;
            valid_r <= 1'b1;
        end else if (drain_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.word_out   = word_r;
    assign bus.ones_cnt   = ones_r;
    assign bus.word_valid = valid_r;
    assign bus.overflow   = ovf_r;

endmodule

// File: tb/tb_fsm_out_deserializer.sv
// tb_fsm_out_deserializer
// Directed scenarios followed by random traffic, all compared every cycle
// against a queue-based model of the two-word buffer.
module tb_fsm_out_deserializer;

    localparam int WIDTH = 8;

    logic CLK = 1'b0;
    logic Reset_n;

    always #5 CLK = ~CLK;

    fsm_out_deserializer_if #(.WIDTH(WIDTH)) bus ();

    fsm_out_deserializer #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bits of the word being gathered, an optional completed
    // word waiting for the output slot, and the visible output slot.
    bit          part_q[$];
    bit          have_full;
    logic [31:0] full_w;
    logic [31:0] m_word;
    logic [31:0] m_ones;
    bit          m_valid;
    bit          m_ovf;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_bits();
        logic [31:0] w = 32'd0;
        foreach (part_q[i]) w = (w << 1) | {31'd0, part_q[i]};
        return w;
    endfunction

    task automatic model_reset();
        part_q.delete();
        have_full = 1'b0;
        full_w    = 32'd0;
        m_word    = 32'd0;
        m_ones    = 32'd0;
        m_valid   = 1'b0;
        m_ovf     = 1'b0;
    endtask

    task automatic model_edge(input bit bv, input bit y, input bit rdy, input bit clr);
        bit          drain;
        bit          new_word;
        logic [31:0] w;
        drain    = m_valid && rdy;
        new_word = 1'b0;
        if (clr) begin
            part_q.delete();
            have_full = 1'b0;
            m_ovf     = 1'b0;
        end else if (have_full) begin
            if (drain) begin
                m_word    = full_w;
                new_word  = 1'b1;
                have_full = 1'b0;
                if (bv) part_q.push_back(y);
            end else if (bv) begin
                m_ovf = 1'b1;
            end
        end else if (bv) begin
            part_q.push_back(y);
            if (part_q.size() == WIDTH) begin
                w = pack_bits();
                part_q.delete();
                if (!m_valid || drain) begin
                    m_word   = w;
                    new_word = 1'b1;
                end else begin
                    full_w    = w;
                    have_full = 1'b1;
                end
            end
        end
        if (new_word) begin
            m_valid = 1'b1;
            m_ones  = $countones(m_word);
        end else if (drain) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_val("word_out",   {{(32-WIDTH){1'b0}}, bus.word_out}, m_word);
        check_val("ones_cnt",   32'(bus.ones_cnt), m_ones);
        check_val("word_valid", {31'd0, bus.word_valid}, {31'd0, m_valid});
        check_val("overflow",   {31'd0, bus.overflow}, {31'd0, m_ovf});
    endtask

    task automatic step(input bit bv, input bit y, input bit rdy, input bit clr);
        bus.bit_valid  = bv;
        bus.y_in       = y;
        bus.word_ready = rdy;
        bus.clear      = clr;
        @(posedge CLK);
        model_edge(bv, y, rdy, clr);
        #1;
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rdy);
        logic [7:0] v;
        v = b;
        for (int i = 7; i >= 0; i--) step(1'b1, v[i], rdy, 1'b0);
    endtask

    initial begin
        Reset_n        = 1'b0;
        bus.y_in       = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.clear      = 1'b0;
        bus.word_ready = 1'b0;
        model_reset();
        #12;
        compare_all();
        Reset_n = 1'b1;

        // Basic pack.
        send_byte(8'hB2, 1'b1);
        check_val("basic_word", {24'd0, bus.word_out}, 32'hB2);
        check_val("basic_ones", 32'(bus.ones_cnt), 32'd4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("basic_one_cycle", {31'd0, bus.word_valid}, 32'd0);

        // Back-pressure into the stall and overflow.
        send_byte(8'hFF, 1'b0);
        send_byte(8'h0F, 1'b0);
        check_val("bp_hold", {24'd0, bus.word_out}, 32'hFF);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("bp_ovf", {31'd0, bus.overflow}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("bp_second", {24'd0, bus.word_out}, 32'h0F);
        check_val("bp_second_ones", 32'(bus.ones_cnt), 32'd4);
        check_val("bp_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Drain plus new bit while stalled.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h96, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_val("stall_drain_word", {24'd0, bus.word_out}, 32'h96);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check_val("stall_next_word", {24'd0, bus.word_out}, 32'h80);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Clear mid-word.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        send_byte(8'h01, 1'b1);
        check_val("clear_word", {24'd0, bus.word_out}, 32'h01);
        check_val("clear_ones", 32'(bus.ones_cnt), 32'd1);
        check_val("clear_ovf", {31'd0, bus.overflow}, 32'd0);

        // Asynchronous reset mid-word with a word valid.
        send_byte(8'h77, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2 Reset_n = 1'b1;
        send_byte(8'hA5, 1'b1);
        check_val("post_reset_word", {24'd0, bus.word_out}, 32'hA5);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped valid.
        for (int i = 0; i < 16; i++) step(bit'(i % 2), 1'b1, 1'b1, 1'b0);
        check_val("gap_word", {24'd0, bus.word_out}, 32'hFF);
        check_val("gap_ones", 32'(bus.ones_cnt), 32'd8);
        check_val("gap_valid", {31'd0, bus.word_valid}, 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
